// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift feeder: controller states and
// the saturation ceiling of the mismatch counter.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    localparam logic [7:0] ERR_SAT = 8'hFF;

endpackage

// File: rtl/shift_feeder.sv
// Serialises a parallel word MSB-first into a downstream shift register,
// waits a configurable settle time, then reads the register taps back and
// reports whether they hold the word that was sent.
module shift_feeder #(
    parameter int WIDTH  = 3,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sr_en,
    output logic             sr_din,
    input  logic [WIDTH-1:0] tap_in,
    output logic             done,
    output logic             match,
    output logic [7:0]       err_cnt
);
    // The module parameter SETTLE shadows the state name, so that state is
    // always written with its package prefix.
    import shift_pkg::state_t;
    import shift_pkg::IDLE;
    import shift_pkg::SHIFT;
    import shift_pkg::CHECK;
    import shift_pkg::ERR_SAT;

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [2:0]     STL_LAST = 3'((SETTLE > 0) ? SETTLE - 1 : 0);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [2:0]       stl_cnt;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] shreg;
    logic             accept;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == ERR_SAT) ? v : v + 8'd1;
    endfunction

    assign accept = in_valid && in_ready;

    // match is only meaningful while done is high; taps are looked at in CHECK only
    assign match = done && (tap_in == word);

    // Data path: capture the word once, then shift the remaining bits toward the MSB
    always_ff @(posedge clk) begin
        if (accept) begin
            word  <= in_data;
            shreg <= in_data << 1;
        end else if (state == SHIFT) begin
            shreg <= shreg << 1;
        end
    end

    // Controller: sequences shift, settle and check, with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            sr_en    <= 1'b0;
            sr_din   <= 1'b0;
            done     <= 1'b0;
            err_cnt  <= 8'd0;
            cnt      <= '0;
            stl_cnt  <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        sr_en    <= 1'b1;
                        sr_din   <= in_data[WIDTH-1];
                        cnt      <= '0;
                    end
                end
                SHIFT: begin
                    if (cnt == CNT_LAST) begin
                        sr_en  <= 1'b0;
                        sr_din <= 1'b0;
                        cnt    <= '0;
                        if (SETTLE == 0) begin
                            state <= CHECK;
                            done  <= 1'b1;
                        end else begin
                            state   <= shift_pkg::SETTLE;
                            stl_cnt <= 3'd0;
                        end
                    end else begin
                        cnt    <= cnt + CW'(1);
                        sr_din <= shreg[WIDTH-1];
                    end
                end
                shift_pkg::SETTLE: begin
                    if (stl_cnt == STL_LAST) begin
                        state   <= CHECK;
                        done    <= 1'b1;
                        stl_cnt <= 3'd0;
                    end else begin
                        stl_cnt <= stl_cnt + 3'd1;
                    end
                end
                CHECK: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    if (tap_in != word) begin
                        err_cnt <= sat_inc(err_cnt);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_feeder.sv
// Bench for shift_feeder: a 3-bit/settle-1 instance and a 4-bit/settle-0
// instance, driven by directed and random words and checked cycle by cycle
// against a word-level model of the expected serial waveform and counters.
module tb_shift_feeder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       a_in_valid = 1'b0;
    logic [2:0] a_in_data = '0;
    logic       a_in_ready, a_sr_en, a_sr_din, a_done, a_match;
    logic [2:0] a_tap = '0;
    logic [7:0] a_err_cnt;

    logic       b_in_valid = 1'b0;
    logic [3:0] b_in_data = '0;
    logic       b_in_ready, b_sr_en, b_sr_din, b_done, b_match;
    logic [3:0] b_tap = '0;
    logic [7:0] b_err_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int a_err_model = 0;
    int b_err_model = 0;
    int prev_hs = -1;

    shift_feeder #(.WIDTH(3), .SETTLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_ready(a_in_ready), .sr_en(a_sr_en), .sr_din(a_sr_din),
        .tap_in(a_tap), .done(a_done), .match(a_match), .err_cnt(a_err_cnt)
    );

    shift_feeder #(.WIDTH(4), .SETTLE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .sr_en(b_sr_en), .sr_din(b_sr_din),
        .tap_in(b_tap), .done(b_done), .match(b_match), .err_cnt(b_err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    function automatic int sat_model(input int e, input bit mismatch);
        if (mismatch && e < 255) return e + 1;
        return e;
    endfunction

    // Called at the sample point of an IDLE cycle where in_ready is expected
    // high; returns at the sample point of the cycle after done.
    task automatic send_a(input logic [2:0] data, input logic [2:0] taps, input bit chk_period);
        chk("a_ready_before", a_in_ready, 1);
        if (chk_period && prev_hs >= 0) chk("a_period", cyc - prev_hs, 6);
        prev_hs = cyc;
        a_in_data  = data;
        a_in_valid = 1'b1;
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            a_in_data  = 3'($urandom);
            a_in_valid = 1'($urandom);
            a_tap      = 3'($urandom);
            #1;
            chk("a_sr_en", a_sr_en, 1);
            chk("a_sr_din", a_sr_din, data[2-k]);
            chk("a_ready_shift", a_in_ready, 0);
            chk("a_done_shift", {a_done, a_match}, 0);
            next_cycle();
        end
        a_tap = 3'($urandom);
        #1;
        chk("a_settle_idle_out", {a_sr_en, a_sr_din, a_done, a_match, a_in_ready}, 0);
        next_cycle();
        a_in_valid = 1'b0;
        a_tap = taps;
        #1;
        chk("a_done", a_done, 1);
        chk("a_match", a_match, (taps == data));
        chk("a_check_sr", {a_sr_en, a_sr_din}, 0);
        a_err_model = sat_model(a_err_model, taps != data);
        next_cycle();
        chk("a_done_after", {a_done, a_match}, 0);
        chk("a_ready_after", a_in_ready, 1);
        chk("a_err_cnt", a_err_cnt, a_err_model);
    endtask

    task automatic send_b(input logic [3:0] data, input logic [3:0] taps);
        chk("b_ready_before", b_in_ready, 1);
        b_in_data  = data;
        b_in_valid = 1'b1;
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            b_in_data  = 4'($urandom);
            b_in_valid = 1'($urandom);
            b_tap      = 4'($urandom);
            #1;
            chk("b_sr_en", b_sr_en, 1);
            chk("b_sr_din", b_sr_din, data[3-k]);
            chk("b_done_shift", b_done, 0);
            next_cycle();
        end
        b_in_valid = 1'b0;
        b_tap = taps;
        #1;
        chk("b_done", b_done, 1);
        chk("b_match", b_match, (taps == data));
        chk("b_check_sr", {b_sr_en, b_sr_din}, 0);
        b_err_model = sat_model(b_err_model, taps != data);
        next_cycle();
        chk("b_done_after", b_done, 0);
        chk("b_ready_after", b_in_ready, 1);
        chk("b_err_cnt", b_err_cnt, b_err_model);
    endtask

    initial begin
        logic [2:0] d3;
        logic [3:0] d4;

        // reset values while rst_n is low
        #3;
        chk("a_reset_out", {a_in_ready, a_sr_en, a_sr_din, a_done, a_match}, 0);
        chk("a_reset_err", a_err_cnt, 0);
        chk("b_reset_out", {b_in_ready, b_sr_en, b_sr_din, b_done, b_match}, 0);
        next_cycle();
        a_in_valid = 1'b1;
        a_in_data  = 3'b111;
        rst_n = 1'b1;
        #1;
        chk("a_ready_pre_edge", a_in_ready, 0);
        next_cycle();
        chk("a_ready_first_edge", a_in_ready, 1);
        chk("b_ready_first_edge", b_in_ready, 1);
        a_in_valid = 1'b0;

        // directed words: matching and mismatching taps
        send_a(3'b101, 3'b101, 1'b0);
        chk("a_err_after_match", a_err_cnt, 0);
        send_a(3'b101, 3'b100, 1'b0);
        chk("a_err_after_mismatch", a_err_cnt, 1);

        // back-to-back random words, handshake period checked
        prev_hs = -1;
        for (int i = 0; i < 4; i++) begin
            d3 = 3'($urandom);
            send_a(d3, ($urandom_range(0, 1) == 1) ? d3 : 3'($urandom), 1'b1);
        end

        // forced mismatches drive the error counter into saturation
        for (int i = 0; i < 260; i++) begin
            d3 = 3'($urandom);
            send_a(d3, d3 ^ 3'(1 + $urandom_range(0, 6)), 1'b0);
        end
        chk("a_err_saturated", a_err_cnt, 255);

        // reset during the second shift cycle abandons the word
        a_in_data  = 3'b110;
        a_in_valid = 1'b1;
        next_cycle();
        a_in_valid = 1'b0;
        next_cycle();
        chk("a_sr_en_before_rst", a_sr_en, 1);
        rst_n = 1'b0;
        #1;
        chk("a_rst_async_out", {a_sr_en, a_sr_din, a_in_ready, a_done}, 0);
        chk("a_rst_async_err", a_err_cnt, 0);
        a_err_model = 0;
        b_err_model = 0;
        next_cycle();
        rst_n = 1'b1;
        #1;
        chk("a_ready_rel_pre_edge", a_in_ready, 0);
        next_cycle();
        chk("a_ready_after_release", a_in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            a_tap = 3'($urandom);
            #1;
            chk("a_no_done_after_rst", {a_done, a_sr_en}, 0);
            next_cycle();
        end
        chk("a_err_after_rst", a_err_cnt, 0);
        send_a(3'b011, 3'b011, 1'b0);

        // zero-settle instance: directed word then random words
        send_b(4'b0110, 4'b0110);
        for (int i = 0; i < 5; i++) begin
            d4 = 4'($urandom);
            send_b(d4, ($urandom_range(0, 1) == 1) ? d4 : 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_feeder.md
SHIFT_FEEDER -- requirements
Module: shift_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 3, giving the serial word length and the number of downstream shift-register taps (legal 2..16).
REQ-002 SHALL have parameter SETTLE, default 1, giving the cycles waited after the last shift before the taps are sampled (legal 0..7).
REQ-003 SHALL have port clk  in  1  single clock, all state on posedge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  in  1  parallel word offered.
REQ-006 SHALL have port in_data  in  WIDTH  parallel word; in_data[WIDTH-1] is sent first.
REQ-007 SHALL have port in_ready  out  1  block can accept a word.
REQ-008 SHALL have port sr_en  out  1  shift enable to the downstream shift register.
REQ-009 SHALL have port sr_din  out  1  serial data to the downstream shift register.
REQ-010 SHALL have port tap_in  in  WIDTH  downstream taps; tap_in[0] holds the most recently shifted bit.
REQ-011 SHALL have port done  out  1  one-cycle pulse when a word completes.
REQ-012 SHALL have port match  out  1  valid with done; 1 when the sampled taps equal the sent word.
REQ-013 SHALL have port err_cnt  out  8  count of mismatching words, saturating.

Function
REQ-014 SHALL implement a state machine with states IDLE, SHIFT, SETTLE and CHECK.
REQ-015 SHALL drive in_ready=1 only in IDLE; a handshake is in_valid&&in_ready on a clock edge.
REQ-016 SHALL, on a handshake at edge t, capture in_data into a word register and a shift register and enter SHIFT.
REQ-017 SHALL hold sr_en=1 for exactly WIDTH consecutive cycles after that edge, with sr_din = word bit WIDTH-1-k in SHIFT cycle k (MSB first).
REQ-018 SHALL hold sr_en=0 and sr_din=0 in every state other than SHIFT.
REQ-019 SHALL keep a shift counter of $clog2(WIDTH+1) bits and leave SHIFT when the counter reaches WIDTH-1; it shall never wrap inside SHIFT.
REQ-020 SHALL stay in SETTLE for SETTLE cycles; when SETTLE=0, SHIFT goes directly to CHECK.
REQ-021 SHALL, in CHECK, compare tap_in against the captured word, assert done=1 and match=(tap_in==word) for one cycle, then return to IDLE.
REQ-022 SHALL hold match at 0 whenever done=0.
REQ-023 SHALL increment err_cnt on every done with match=0, and hold it at 255 once it reaches 255.
REQ-024 SHALL give a back-to-back throughput of one word per WIDTH+SETTLE+2 cycles: in_ready returns the cycle after done.
REQ-025 SHALL ignore in_valid and in_data while not in IDLE; no input is queued.
REQ-026 SHALL sample tap_in only in CHECK; tap_in changes in other states have no effect.

Reset
REQ-027 SHALL, while rst_n=0, force state=IDLE, in_ready=0, sr_en=0, sr_din=0, done=0, match=0, err_cnt=0 and the counters to 0, immediately and without waiting for a clock.
REQ-028 SHALL assert in_ready=1 on the first clock edge after rst_n deasserts.
REQ-029 SHALL abandon a word interrupted by reset mid-operation, with no done pulse and no change to err_cnt.

Structure
REQ-030 SHALL take the state enumeration (IDLE, SHIFT, SETTLE, CHECK) and the err_cnt saturation constant 8'hFF from the shared package shift_pkg.
REQ-031 SHALL be a single module with no sub-modules.

Verification
REQ-032 SHALL cover: WIDTH=3, SETTLE=1, in_data=3'b101 accepted at cycle 0 -> sr_en=1 in cycles 1-3 with sr_din 1,0,1; tap_in=3'b101 -> done=1 and match=1 at cycle 5; err_cnt stays 0.
REQ-033 SHALL cover: the same word with tap_in=3'b100 -> done=1 and match=0 at cycle 5; err_cnt becomes 1.
REQ-034 SHALL cover: in_valid held high for 4 words -> handshakes every 6 cycles (WIDTH+SETTLE+2); in_data changes during SHIFT do not alter sr_din.
REQ-035 SHALL cover: rst_n pulsed low in SHIFT cycle 2 -> sr_en=0 asynchronously; no done pulse; in_ready=1 one edge after release.
REQ-036 SHALL cover: 260 forced mismatches -> err_cnt saturates at 255.
REQ-037 SHALL cover: SETTLE=0, WIDTH=4, in_data=4'b0110 -> done at cycle 5, with no SETTLE state visited.
